// File: rtl/pio_bus_cycle_ctrl.sv
// Bus-cycle controller for the FF8000-FFBFFF peripheral window: conditions the 68000 strobes,
// latches address/direction for the PIO decoder, times wait states and raises DTACK or BERR.
module pio_bus_cycle_ctrl #(
  parameter int unsigned WS0     = 1,
  parameter int unsigned WS1     = 3,
  parameter int unsigned WS2     = 2,
  parameter int unsigned WS3     = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        as_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        cpu_rw_n,
  input  logic [23:1] cpu_addr,
  input  logic        usb_ready,
  output logic        cs,
  output logic        rw_n,
  output logic [2:0]  adm,
  output logic [1:0]  adl,
  output logic        dtack_n,
  output logic        berr_n
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StActive,
    StAck,
    StBerr
  } state_e;

  localparam logic [7:0] Ws0Cnt      = 8'(WS0);
  localparam logic [7:0] Ws1Cnt      = 8'(WS1);
  localparam logic [7:0] Ws2Cnt      = 8'(WS2);
  localparam logic [7:0] Ws3Cnt      = 8'(WS3);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] tmo_q, tmo_d;
  logic       as_meta_q, as_s_q;
  logic       uds_meta_q, uds_s_q;
  logic       lds_meta_q, lds_s_q;
  logic       cs_q, cs_d;
  logic       rw_q, rw_d;
  logic [2:0] adm_q, adm_d;
  logic [1:0] adl_q, adl_d;
  logic       dtack_q, dtack_d;
  logic       berr_q, berr_d;

  logic       as_s;
  logic       ds_s;
  logic       win_hit;
  logic       tmo_hit;
  logic       usb_region;
  logic [7:0] ws_sel;
  logic       unused_addr;

  assign as_s = as_s_q;
  assign ds_s = uds_s_q & lds_s_q;  // low when either data strobe is low

  // The address is stable while as_n is low, so decoding it unsynchronised is safe.
  assign win_hit     = (cpu_addr[23:15] == 9'h1FF) && !cpu_addr[14];
  assign unused_addr = ^{cpu_addr[11:8], cpu_addr[5:1]};

  assign tmo_hit    = (tmo_q == TimeoutLast);
  assign usb_region = (adm_q[1:0] == 2'd2);

  always_comb begin
    ws_sel = Ws0Cnt;
    unique case (adm_q[1:0])
      2'd0:    ws_sel = Ws0Cnt;
      2'd1:    ws_sel = Ws1Cnt;
      2'd2:    ws_sel = Ws2Cnt;
      2'd3:    ws_sel = Ws3Cnt;
      default: ws_sel = Ws0Cnt;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    rw_d    = rw_q;
    adm_d   = adm_q;
    adl_d   = adl_q;

    unique case (state_q)
      StIdle: begin
        tmo_d = 8'd0;
        if (!as_s && win_hit) begin
          state_d = StSetup;
          rw_d    = cpu_rw_n;
          adm_d   = cpu_addr[14:12];
          adl_d   = cpu_addr[7:6];
        end
      end
      StSetup: begin
        tmo_d = tmo_q + 8'd1;
        if (as_s) begin
          state_d = StIdle;
        end else if (tmo_hit) begin
          state_d = StBerr;
        end else if (rw_q || !ds_s) begin
          state_d = StActive;
          wait_d  = ws_sel;
        end
      end
      StActive: begin
        tmo_d  = tmo_q + 8'd1;
        wait_d = (wait_q != 8'd0) ? wait_q - 8'd1 : 8'd0;
        // Abort beats timeout, and timeout beats acknowledge.
        if (as_s) begin
          state_d = StIdle;
        end else if (tmo_hit) begin
          state_d = StBerr;
        end else if ((wait_q == 8'd0) && (!usb_region || usb_ready)) begin
          state_d = StAck;
        end
      end
      StAck: begin
        if (as_s) state_d = StIdle;
      end
      StBerr: begin
        if (as_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they change on the transition edge.
    cs_d    = (state_d == StActive) || (state_d == StAck);
    dtack_d = (state_d != StAck);
    berr_d  = (state_d != StBerr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      as_meta_q  <= 1'b1;
      as_s_q     <= 1'b1;
      uds_meta_q <= 1'b1;
      uds_s_q    <= 1'b1;
      lds_meta_q <= 1'b1;
      lds_s_q    <= 1'b1;
    end else begin
      as_meta_q  <= as_n;
      as_s_q     <= as_meta_q;
      uds_meta_q <= uds_n;
      uds_s_q    <= uds_meta_q;
      lds_meta_q <= lds_n;
      lds_s_q    <= lds_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= 8'd0;
      tmo_q   <= 8'd0;
      cs_q    <= 1'b0;
      rw_q    <= 1'b1;
      adm_q   <= 3'd0;
      adl_q   <= 2'd0;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      cs_q    <= cs_d;
      rw_q    <= rw_d;
      adm_q   <= adm_d;
      adl_q   <= adl_d;
      dtack_q <= dtack_d;
      berr_q  <= berr_d;
    end
  end

  assign cs      = cs_q;
  assign rw_n    = rw_q;
  assign adm     = adm_q;
  assign adl     = adl_q;
  assign dtack_n = dtack_q;
  assign berr_n  = berr_q;

  a_ack_berr_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(!dtack_q && !berr_q));

  a_idle_cs_low : assert property (@(posedge clk) disable iff (reset)
    (state_q == StIdle) |-> !cs_q);

endmodule

// File: tb/tb_pio_bus_cycle_ctrl.sv
// Self-checking bench for pio_bus_cycle_ctrl: directed and random bus cycles checked edge by edge
// against expected event times derived from the cycle timing rules.
module tb_pio_bus_cycle_ctrl;

  localparam int Timeout = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        as_n, uds_n, lds_n, cpu_rw_n, usb_ready;
  logic [23:1] cpu_addr;
  logic        cs, rw_n, dtack_n, berr_n;
  logic [2:0]  adm;
  logic [1:0]  adl;

  int vectors     = 0;
  int miscompares = 0;
  int ws_tab[4]   = '{1, 3, 2, 1};

  // Reference copy of the latched address/direction.
  logic [2:0] m_adm;
  logic [1:0] m_adl;
  logic       m_rw;

  pio_bus_cycle_ctrl #(
    .WS0(1), .WS1(3), .WS2(2), .WS3(1), .TIMEOUT(Timeout)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .as_n     (as_n),
    .uds_n    (uds_n),
    .lds_n    (lds_n),
    .cpu_rw_n (cpu_rw_n),
    .cpu_addr (cpu_addr),
    .usb_ready(usb_ready),
    .cs       (cs),
    .rw_n     (rw_n),
    .adm      (adm),
    .adl      (adl),
    .dtack_n  (dtack_n),
    .berr_n   (berr_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int edge_n, input logic [7:0] got,
                       input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s edge %0d: observed %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic check_all(input int edge_n, input logic e_cs, input logic e_dtack,
                           input logic e_berr);
    check("cs", edge_n, 8'(cs), 8'(e_cs));
    check("dtack_n", edge_n, 8'(dtack_n), 8'(e_dtack));
    check("berr_n", edge_n, 8'(berr_n), 8'(e_berr));
    check("adm", edge_n, 8'(adm), 8'(m_adm));
    check("adl", edge_n, 8'(adl), 8'(m_adl));
    check("rw_n", edge_n, 8'(rw_n), 8'(m_rw));
  endtask

  // One bus cycle, starting just after a clock edge (edge 0). Strobes/usb_ready/reset change
  // just after edges t_ds, u, r and rst_at respectively (rst_at = 0 means no reset).
  task automatic run_cycle(input logic [23:0] ba, input logic rd, input int t_ds, input int u,
                           input int r, input int rst_at);
    int  e, a_edge, k, t, i_edge, stop, total, rst_edge, ds_seen;
    bit  hit, abort_c, tout, acked;
    logic e_cs, e_dtack, e_berr;

    hit      = (ba[23:15] == 9'h1FF) && !ba[14];
    e        = 3;                                // two synchroniser flops, then the FSM
    ds_seen  = (rd ? 0 : t_ds) + 2;
    a_edge   = ((ds_seen > e) ? ds_seen : e) + 1;
    k        = a_edge + 1 + ws_tab[ba[13:12]];
    if (ba[13:12] == 2'd2 && u + 1 > k) k = u + 1;
    t        = e + Timeout;
    i_edge   = r + 3;
    abort_c  = (i_edge <= k) && (i_edge <= t);
    tout     = !abort_c && (t <= k);
    acked    = !abort_c && !tout;
    stop     = tout ? t : i_edge;
    rst_edge = (rst_at > 0) ? rst_at + 1 : 32'h3fff_ffff;
    total    = ((rst_at > 0) ? rst_at + 1 : i_edge) + 3;

    cpu_addr  = ba[23:1];
    cpu_rw_n  = rd;
    as_n      = 1'b0;
    usb_ready = (u == 0);
    if (t_ds == 0) begin
      uds_n = 1'b0;
      lds_n = 1'b0;
    end

    for (int n = 1; n <= total; n++) begin
      @(posedge clk);
      #1;
      if (n >= rst_edge) begin
        m_adm = 3'd0; m_adl = 2'd0; m_rw = 1'b1;
        e_cs = 1'b0; e_dtack = 1'b1; e_berr = 1'b1;
      end else begin
        if (hit && n == e) begin
          m_adm = ba[14:12]; m_adl = ba[7:6]; m_rw = rd;
        end
        e_cs    = hit && (n >= a_edge) && (n < stop);
        e_dtack = !(hit && acked && (n >= k) && (n < i_edge));
        e_berr  = !(hit && tout && (n >= t) && (n < i_edge));
      end
      check_all(n, e_cs, e_dtack, e_berr);

      if (t_ds > 0 && n == t_ds) begin
        uds_n = 1'b0;
        lds_n = 1'b0;
      end
      if (n == u) usb_ready = 1'b1;
      if (n == r) begin
        as_n  = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
      end
      if (rst_at > 0 && n == rst_at) reset = 1'b1;
      if (rst_at > 0 && n == rst_at + 1) reset = 1'b0;
    end
    usb_ready = 1'b0;
  endtask

  initial begin
    logic [23:0] ba;
    logic        rd;
    int          r, t_ds, u, cat;

    reset = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    cpu_rw_n = 1'b1; cpu_addr = '0; usb_ready = 1'b0;
    m_adm = 3'd0; m_adl = 2'd0; m_rw = 1'b1;

    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      check_all(-1, 1'b0, 1'b1, 1'b1);
    end
    reset = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk);
      #1;
      check_all(0, 1'b0, 1'b1, 1'b1);
    end

    run_cycle(24'hFF8040, 1'b0, 0, 0, 6, 0);        // write, region 0, strobes aligned
    run_cycle(24'hFF9000, 1'b1, 0, 0, 8, 0);        // read, region 1
    run_cycle(24'hFFA000, 1'b1, 0, 15, 16, 0);      // read, USB not ready for a while
    run_cycle(24'hFFA000, 1'b1, 0, 100000, 270, 0); // USB never ready: bus error
    run_cycle(24'hFFC000, 1'b1, 0, 0, 8, 0);        // outside window
    run_cycle(24'h000000, 1'b0, 0, 0, 8, 0);        // outside window
    run_cycle(24'hFF9000, 1'b1, 0, 0, 3, 0);        // abort in ACTIVE
    run_cycle(24'hFFB080, 1'b0, 3, 0, 12, 0);       // write with late data strobe
    run_cycle(24'hFF8040, 1'b0, 0, 0, 7, 7);        // reset while in ACK

    for (int i = 0; i < 60; i++) begin
      cat = $urandom_range(0, 5);
      if (cat < 4) ba = {9'h1FF, 1'b0, 2'(cat), 12'($urandom)};
      else if (cat == 4) ba = {10'h3FF, 14'($urandom)};
      else ba = 24'($urandom);
      rd   = 1'($urandom);
      r    = $urandom_range(1, 25);
      t_ds = rd ? 0 : $urandom_range(0, (r - 1 < 4) ? r - 1 : 4);
      u    = $urandom_range(0, 14);
      run_cycle(ba, rd, t_ds, u, r, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
